bcd_display_mux: RTL and testbench

//  Downstream stage of the 2-digit BCD counter. Consumes units/tens/F and drives a

---
 rtl/bcd_display_if.sv | 11 +
 rtl/bcd_display_mux.sv | 185 ++++++++++++++++++
 tb/tb_bcd_display_mux.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/bcd_display_if.sv
// Bundles the counter-facing inputs and display-facing outputs of the BCD display mux.
interface bcd_display_if;
  logic [3:0] units;
  logic [3:0] tens;
  logic       f;
  logic [6:0] seg;
  logic [1:0] an;

  modport master (output units, output tens, output f, input seg, input an);
  modport slave  (input units, input tens, input f, output seg, output an);
endinterface

// File: rtl/bcd_display_mux.sv
// Time-multiplexed 2-digit 7-segment driver with per-frame input snapshot,
// leading-zero blanking, flag-driven blink and an inter-digit guard gap.
module bcd_display_mux #(
  parameter int REFRESH_DIV    = 4,
  parameter int GUARD_CYCLES   = 1,
  parameter int BLINK_FRAMES   = 64,
  parameter int BLANK_LZ       = 1,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int AN_ACTIVE_LOW  = 0
) (
  input  logic         clk,
  input  logic         reset,
  bcd_display_if.slave disp
);

  localparam int MAX_DWELL = (REFRESH_DIV > GUARD_CYCLES) ? REFRESH_DIV : GUARD_CYCLES;
  localparam int DW        = (MAX_DWELL > 1) ? $clog2(MAX_DWELL) : 1;
  localparam int FW        = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [DW-1:0] REF_LAST = DW'(REFRESH_DIV - 1);
  localparam logic [DW-1:0] GRD_LAST = DW'(GUARD_CYCLES - 1);
  localparam logic [FW-1:0] FRM_LAST = FW'(BLINK_FRAMES - 1);
  localparam logic [6:0]    SEG_OFF  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic [1:0]    AN_OFF   = (AN_ACTIVE_LOW != 0) ? 2'b11 : 2'b00;

  typedef enum logic [2:0] {
    S_LOAD  = 3'd0,
    S_UNITS = 3'd1,
    S_GAP0  = 3'd2,
    S_TENS  = 3'd3,
    S_GAP1  = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [3:0]    sh_u_q, sh_u_d;
  logic [3:0]    sh_t_q, sh_t_d;
  logic          sh_f_q, sh_f_d;
  logic [FW-1:0] frame_cnt_q, frame_cnt_d;
  logic          blink_phase_q, blink_phase_d;
  logic          dark_q, dark_d;
  logic [6:0]    seg_q, seg_d;
  logic [1:0]    an_q, an_d;
  logic          dwell_last_s;
  logic [6:0]    seg_lit_s;
  logic [1:0]    an_lit_s;

  function automatic logic [6:0] dec7(input logic [3:0] d);
    logic [6:0] r;
    case (d)
      4'd0:    r = 7'h3F;
      4'd1:    r = 7'h06;
      4'd2:    r = 7'h5B;
      4'd3:    r = 7'h4F;
      4'd4:    r = 7'h66;
      4'd5:    r = 7'h6D;
      4'd6:    r = 7'h7D;
      4'd7:    r = 7'h07;
      4'd8:    r = 7'h7F;
      4'd9:    r = 7'h6F;
      default: r = 7'h40;
    endcase
    return r;
  endfunction

  // Frame sequencer, snapshot capture and blink bookkeeping.
  always_comb begin
    state_d       = state_q;
    dwell_d       = dwell_q;
    sh_u_d        = sh_u_q;
    sh_t_d        = sh_t_q;
    sh_f_d        = sh_f_q;
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    dark_d        = dark_q;
    if ((state_q == S_UNITS) || (state_q == S_TENS)) begin
      dwell_last_s = (dwell_q == REF_LAST);
    end else begin
      dwell_last_s = (dwell_q == GRD_LAST);
    end
    case (state_q)
      S_LOAD: begin
        state_d = S_UNITS;
        dwell_d = {DW{1'b0}};
        sh_u_d  = disp.units;
        sh_t_d  = disp.tens;
        sh_f_d  = disp.f;
        // The frame being started is dark when the phase entering it was already set.
        dark_d  = blink_phase_q & disp.f;
        if (disp.f) begin
          if (frame_cnt_q == FRM_LAST) begin
            frame_cnt_d   = {FW{1'b0}};
            blink_phase_d = ~blink_phase_q;
          end else begin
            frame_cnt_d   = frame_cnt_q + FW'(1);
            blink_phase_d = blink_phase_q;
          end
        end else begin
          frame_cnt_d   = {FW{1'b0}};
          blink_phase_d = 1'b0;
        end
      end
      S_UNITS, S_GAP0, S_TENS, S_GAP1: begin
        if (dwell_last_s) begin
          dwell_d = {DW{1'b0}};
          case (state_q)
            S_UNITS: state_d = S_GAP0;
            S_GAP0:  state_d = S_TENS;
            S_TENS:  state_d = S_GAP1;
            default: state_d = S_LOAD;
          endcase
        end else begin
          dwell_d = dwell_q + DW'(1);
        end
      end
      default: begin
        state_d = S_LOAD;
        dwell_d = {DW{1'b0}};
      end
    endcase
  end

  // Next output levels are decoded from next-state registers so the ports come straight off flops.
  always_comb begin
    an_lit_s  = 2'b00;
    seg_lit_s = 7'h00;
    if (!dark_d) begin
      case (state_d)
        S_UNITS: begin
          an_lit_s  = 2'b01;
          seg_lit_s = dec7(sh_u_d);
        end
        S_TENS: begin
          if ((BLANK_LZ != 0) && (sh_t_d == 4'd0)) begin
            an_lit_s  = 2'b00;
            seg_lit_s = 7'h00;
          end else begin
            an_lit_s  = 2'b10;
            seg_lit_s = dec7(sh_t_d);
          end
        end
        default: begin
          an_lit_s  = 2'b00;
          seg_lit_s = 7'h00;
        end
      endcase
    end else begin
      an_lit_s  = 2'b00;
      seg_lit_s = 7'h00;
    end
    seg_d = (SEG_ACTIVE_LOW != 0) ? ~seg_lit_s : seg_lit_s;
    an_d  = (AN_ACTIVE_LOW != 0) ? ~an_lit_s : an_lit_s;
  end

  // State and output registers; reset drives the ports to the off level immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_LOAD;
      dwell_q       <= {DW{1'b0}};
      sh_u_q        <= 4'd0;
      sh_t_q        <= 4'd0;
      sh_f_q        <= 1'b0;
      frame_cnt_q   <= {FW{1'b0}};
      blink_phase_q <= 1'b0;
      dark_q        <= 1'b0;
      seg_q         <= SEG_OFF;
      an_q          <= AN_OFF;
    end else begin
      state_q       <= state_d;
      dwell_q       <= dwell_d;
      sh_u_q        <= sh_u_d;
      sh_t_q        <= sh_t_d;
      sh_f_q        <= sh_f_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
      dark_q        <= dark_d;
      seg_q         <= seg_d;
      an_q          <= an_d;
    end
  end

  assign disp.seg = seg_q;
  assign disp.an  = an_q;

endmodule

// File: tb/tb_bcd_display_mux.sv
// Scoreboard bench: a frame-position reference model queues the expected display
// word each cycle; a monitor pops and compares on the falling edge.
module tb_bcd_display_mux;
  localparam int RD    = 4;
  localparam int GC    = 1;
  localparam int BF    = 2;
  localparam int FRAME = 2 * RD + 2 * GC + 1;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  bcd_display_if if_lz ();
  bcd_display_if if_nolz ();

  bcd_display_mux #(
    .REFRESH_DIV(RD), .GUARD_CYCLES(GC), .BLINK_FRAMES(BF),
    .BLANK_LZ(1), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)
  ) u_lz (.clk(clk), .reset(reset), .disp(if_lz.slave));

  bcd_display_mux #(
    .REFRESH_DIV(RD), .GUARD_CYCLES(GC), .BLINK_FRAMES(BF),
    .BLANK_LZ(0), .SEG_ACTIVE_LOW(0), .AN_ACTIVE_LOW(0)
  ) u_nolz (.clk(clk), .reset(reset), .disp(if_nolz.slave));

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [8:0] q_lz[$];
  logic [8:0] q_nolz[$];
  logic [6:0] seg_tab [0:9] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66,
                               7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  int         pos;
  int         run_len;
  logic [3:0] m_u, m_t;
  logic       m_dark;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    if (d > 4'd9) return 7'h40;
    return seg_tab[d];
  endfunction

  // Expected {an, seg} at frame position p (0 = load slot).
  function automatic logic [8:0] expect_word(input int p, input logic [3:0] su,
                                             input logic [3:0] st, input logic dark,
                                             input bit blz);
    if (dark || p == 0) return 9'h000;
    if (p >= 1 && p <= RD) return {2'b01, seg_of(su)};
    if (p > RD + GC && p <= 2 * RD + GC) begin
      if (blz && st == 4'd0) return 9'h000;
      return {2'b10, seg_of(st)};
    end
    return 9'h000;
  endfunction

  task automatic drive(input logic [3:0] u, input logic [3:0] t, input logic f);
    if_lz.units   = u;
    if_lz.tens    = t;
    if_lz.f       = f;
    if_nolz.units = u;
    if_nolz.tens  = t;
    if_nolz.f     = f;
  endtask

  task automatic wait_pos(input int p);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (pos != p && n < 3 * FRAME);
    if (pos != p) begin
      checks++;
      errors++;
      $display("FAIL wait_pos actual=%0d required=%0d", pos, p);
    end
  endtask

  task automatic frames(input int n);
    repeat (n * FRAME) @(negedge clk);
  endtask

  // Reference model: tracks frame position and blink run length abstractly.
  initial begin
    pos = 0; run_len = 0; m_u = 4'd0; m_t = 4'd0; m_dark = 1'b0;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        pos = 0; run_len = 0; m_u = 4'd0; m_t = 4'd0; m_dark = 1'b0;
        q_lz.delete();
        q_nolz.delete();
        q_lz.push_back(9'h000);
        q_nolz.push_back(9'h000);
      end else begin
        pos = (pos + 1) % FRAME;
        if (pos == 1) begin
          m_u = if_lz.units;
          m_t = if_lz.tens;
          if (if_lz.f) run_len++;
          else run_len = 0;
          m_dark = (run_len > 0) && ((((run_len - 1) / BF) % 2) == 1);
        end
        q_lz.push_back(expect_word(pos, m_u, m_t, m_dark, 1'b1));
        q_nolz.push_back(expect_word(pos, m_u, m_t, m_dark, 1'b0));
      end
    end
  end

  // Monitor: one expected word per DUT per cycle.
  initial begin
    logic [8:0] e;
    forever begin
      @(negedge clk);
      checks++;
      if (q_lz.size() == 0) begin
        errors++;
        $display("FAIL lz_queue_empty actual=empty required=entry");
      end else begin
        e = q_lz.pop_front();
        if ({if_lz.an, if_lz.seg} !== e) begin
          errors++;
          $display("FAIL lz_out t=%0t pos=%0d actual an=%b seg=%h required an=%b seg=%h",
                   $time, pos, if_lz.an, if_lz.seg, e[8:7], e[6:0]);
        end
      end
      checks++;
      if (q_nolz.size() == 0) begin
        errors++;
        $display("FAIL nolz_queue_empty actual=empty required=entry");
      end else begin
        e = q_nolz.pop_front();
        if ({if_nolz.an, if_nolz.seg} !== e) begin
          errors++;
          $display("FAIL nolz_out t=%0t pos=%0d actual an=%b seg=%h required an=%b seg=%h",
                   $time, pos, if_nolz.an, if_nolz.seg, e[8:7], e[6:0]);
        end
      end
    end
  end

  // Stimulus: directed scenarios followed by randomized input changes.
  initial begin
    int         gap;
    logic [3:0] ru, rt;
    logic       rf;
    drive(4'd7, 4'd3, 1'b0);
    repeat (3) @(negedge clk);
    #1 reset = 1'b0;
    frames(2);

    wait_pos(3);
    drive(4'd8, 4'd3, 1'b0);
    frames(2);

    drive(4'd0, 4'd0, 1'b0);
    frames(2);
    drive(4'hC, 4'd3, 1'b0);
    frames(2);

    drive(4'd2, 4'd5, 1'b1);
    frames(9);
    drive(4'd2, 4'd5, 1'b0);
    frames(2);

    drive(4'd6, 4'd1, 1'b0);
    frames(1);
    wait_pos(7);
    @(posedge clk);
    #1 reset = 1'b1;
    #1;
    checks++;
    if ({if_lz.an, if_lz.seg, if_nolz.an, if_nolz.seg} !== 18'h0) begin
      errors++;
      $display("FAIL async_reset actual lz=%b/%h nolz=%b/%h required 00/00",
               if_lz.an, if_lz.seg, if_nolz.an, if_nolz.seg);
    end
    drive(4'd7, 4'd3, 1'b0);
    repeat (2) @(negedge clk);
    #1 reset = 1'b0;
    frames(2);

    rf = 1'b0;
    for (int i = 0; i < 150; i++) begin
      gap = $urandom_range(1, 14);
      repeat (gap) @(negedge clk);
      ru = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 3))
        0:       rt = 4'd0;
        1:       rt = 4'd5;
        default: rt = 4'($urandom_range(0, 15));
      endcase
      if ($urandom_range(0, 3) == 0) rf = ~rf;
      drive(ru, rt, rf);
    end
    frames(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
